fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_buf.sv | 40 ++++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset/NOP constants and HALT decode.
package fetch_stage_pkg;

  localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE   = 5'b00000;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SQUASH = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_stage_buf.sv
// One-entry IF holding buffer: flush beats load, and load beats consume.
module fetch_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        consume_i,
  input  logic        flush_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] seq_pc_i,
  output logic        valid_o,
  output logic [15:0] instr_o,
  output logic [15:0] seq_pc_o
);

  logic        valid_q;
  logic [15:0] instr_q;
  logic [15:0] seq_pc_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      instr_q  <= '0;
      seq_pc_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q  <= 1'b1;
      instr_q  <= instr_i;
      seq_pc_q <= seq_pc_i;
    end else if (consume_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o  = valid_q;
  assign instr_o  = instr_q;
  assign seq_pc_o = seq_pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, request FSM (FETCH/WAIT/SQUASH/HALTED) and the IF/ID holding buffer.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic [15:0] imem_data_i,
  input  logic        imem_done_i,
  output logic [15:0] instruc_o,
  output logic [15:0] seq_PC_o,
  output logic        valid_o
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  addr_q, addr_d;
  logic [15:0]  pc_plus2;
  logic         buf_valid;
  logic [15:0]  buf_instr;
  logic         consume, can_accept, halt_consume, req, load;

  assign consume      = buf_valid && !stall_i;
  assign can_accept   = !buf_valid || consume;
  assign halt_consume = consume && is_halt(buf_instr);
  assign pc_plus2     = pc_q + 16'd2;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req     = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        req = can_accept && !halt_consume;
        if (req && imem_done_i) begin
          load = 1'b1;
          pc_d = pc_plus2;
        end else if (req) begin
          addr_d  = pc_q;
          state_d = ST_WAIT;
        end else if (halt_consume) begin
          state_d = ST_HALTED;
        end
      end
      ST_WAIT: begin
        req = 1'b1;
        if (imem_done_i) begin
          load    = 1'b1;
          pc_d    = pc_plus2;
          state_d = ST_FETCH;
        end
      end
      ST_SQUASH: begin
        req = 1'b1;
        if (imem_done_i) state_d = ST_FETCH;
      end
      ST_HALTED: ;
      default: state_d = ST_FETCH;
    endcase

    // A redirect overrides everything; an access still in flight must drain in SQUASH.
    if (redirect_i) begin
      load    = 1'b0;
      pc_d    = redirect_pc_i;
      state_d = (req && !imem_done_i) ? ST_SQUASH : ST_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  // The request is gated by rst so it drops the moment reset asserts, not at the next edge.
  assign imem_req_o  = rst && req;
  assign imem_addr_o = (state_q == ST_WAIT || state_q == ST_SQUASH) ? addr_q : pc_q;
  assign instruc_o   = buf_valid ? buf_instr : NOP_INSTR;
  assign valid_o     = buf_valid;

  fetch_buf u_buf (
    .clk       (clk),
    .rst_n     (rst),
    .load_i    (load),
    .consume_i (consume),
    .flush_i   (redirect_i),
    .instr_i   (imem_data_i),
    .seq_pc_i  (pc_plus2),
    .valid_o   (buf_valid),
    .instr_o   (buf_instr),
    .seq_pc_o  (seq_PC_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and random checks of fetch_stage against a transaction-level fetch model.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, redirect_i, imem_done_i;
  logic [15:0] redirect_pc_i, imem_data_i;
  logic        imem_req_o, valid_o;
  logic [15:0] imem_addr_o, instruc_o, seq_PC_o;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .imem_done_i   (imem_done_i),
    .instruc_o     (instruc_o),
    .seq_PC_o      (seq_PC_o),
    .valid_o       (valid_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mem [256];

  // Model: fetch address, buffered word, outstanding access (and whether it is doomed), halt flag.
  logic        m_valid, m_halted, m_out, m_squash;
  logic [15:0] m_pc, m_instr, m_seq, m_oaddr;
  logic        e_req, e_cons, e_halt;
  logic [15:0] e_addr;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_halted = 1'b0; m_out = 1'b0; m_squash = 1'b0;
    m_pc = 16'h0000; m_instr = NOP; m_seq = 16'h0000; m_oaddr = 16'h0000;
  endtask

  task automatic model_eval(input logic st);
    e_cons = m_valid && !st;
    e_halt = e_cons && (m_instr[15:11] == 5'b00000);
    if (m_halted) begin
      e_req = 1'b0; e_addr = m_pc;
    end else if (m_out) begin
      e_req = 1'b1; e_addr = m_oaddr;
    end else begin
      e_req = (!m_valid || e_cons) && !e_halt; e_addr = m_pc;
    end
  endtask

  task automatic model_update(input logic rd, input logic [15:0] rpc, input logic d,
                              input logic [15:0] data);
    if (rd) begin
      m_squash = e_req && !d;
      m_out    = m_squash;
      m_oaddr  = e_addr;
      m_pc     = rpc;
      m_valid  = 1'b0;
      m_halted = 1'b0;
    end else begin
      if (e_cons) m_valid = 1'b0;
      if (e_halt) m_halted = 1'b1;
      if (e_req && d) begin
        if (!m_squash) begin
          m_valid = 1'b1; m_instr = data;
          m_seq = e_addr + 16'd2; m_pc = e_addr + 16'd2;
        end
        m_out = 1'b0; m_squash = 1'b0;
      end else if (e_req) begin
        m_out = 1'b1; m_oaddr = e_addr;
      end
    end
  endtask

  // Entered just after a negedge; drives one cycle, compares pre-edge outputs, then clocks.
  task automatic cycle(input logic st, input logic rd, input logic [15:0] rpc, input int done_pct);
    logic        d;
    logic [15:0] data;
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
    #1;
    model_eval(st);
    check("req", imem_req_o, e_req);
    if (e_req) check("addr", imem_addr_o, e_addr);
    check("valid", valid_o, m_valid);
    check("instr", instruc_o, m_valid ? m_instr : NOP);
    check("seq_pc", seq_PC_o, m_seq);
    d    = e_req && ($urandom_range(0, 99) < done_pct);
    data = d ? mem[e_addr[8:1]] : 16'($urandom);
    imem_done_i = d; imem_data_i = data;
    @(posedge clk);
    model_update(rd, rpc, d, data);
    @(negedge clk);
    imem_done_i = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:11] == 5'b00000) w[11] = 1'b1;
      mem[i] = w;
    end
    mem[2]  = 16'h1234;  // word at 0x0004
    mem[16] = 16'h0000;  // HALT at 0x0020

    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_done_i = 1'b0; imem_data_i = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_req", imem_req_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_instr", instruc_o, NOP);
    check("rst_seq", seq_PC_o, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Zero-wait streaming from reset.
    cycle(1'b0, 1'b0, 16'h0, 100);
    check("stream_addr1", imem_addr_o, 16'h0002);
    check("stream_valid1", valid_o, 1'b1);
    check("stream_seq1", seq_PC_o, 16'h0002);
    cycle(1'b0, 1'b0, 16'h0, 100);
    check("stream_addr2", imem_addr_o, 16'h0004);
    check("stream_seq2", seq_PC_o, 16'h0004);
    cycle(1'b0, 1'b0, 16'h0, 100);
    check("stream_seq3", seq_PC_o, 16'h0006);

    // Stall holds 0x1234 for three cycles; fetch resumes at 0x0006.
    repeat (3) begin
      cycle(1'b1, 1'b0, 16'h0, 100);
      check("stall_instr", instruc_o, 16'h1234);
      check("stall_seq", seq_PC_o, 16'h0006);
    end
    cycle(1'b0, 1'b0, 16'h0, 100);

    // Redirect while an access to 0x0010 is outstanding.
    cycle(1'b0, 1'b1, 16'h0010, 100);
    cycle(1'b0, 1'b0, 16'h0, 0);
    check("sq_addr_a", imem_addr_o, 16'h0010);
    cycle(1'b0, 1'b1, 16'h0100, 0);
    check("sq_addr_b", imem_addr_o, 16'h0010);
    cycle(1'b0, 1'b0, 16'h0, 0);
    check("sq_valid", valid_o, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 100);
    check("sq_discard", valid_o, 1'b0);
    check("sq_next_addr", imem_addr_o, 16'h0100);
    cycle(1'b0, 1'b0, 16'h0, 100);
    check("sq_seq", seq_PC_o, 16'h0102);

    // HALT consumed: no requests until a redirect.
    cycle(1'b0, 1'b1, 16'h0020, 100);
    cycle(1'b0, 1'b0, 16'h0, 100);
    check("halt_buffered", instruc_o, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0, 100);
    repeat (10) begin
      cycle(1'b0, 1'b0, 16'h0, 100);
      check("halt_req", imem_req_o, 1'b0);
    end
    cycle(1'b0, 1'b1, 16'h0040, 100);
    check("unhalt_req", imem_req_o, 1'b1);
    check("unhalt_addr", imem_addr_o, 16'h0040);

    // PC wrap.
    cycle(1'b0, 1'b1, 16'hFFFE, 100);
    cycle(1'b0, 1'b0, 16'h0, 100);
    check("wrap_seq", seq_PC_o, 16'h0000);
    check("wrap_addr", imem_addr_o, 16'h0000);

    // Asynchronous reset in the middle of an unfinished access.
    cycle(1'b0, 1'b0, 16'h0, 0);
    #2 rst = 1'b0;
    #1;
    check("arst_req", imem_req_o, 1'b0);
    check("arst_valid", valid_o, 1'b0);
    check("arst_instr", instruc_o, NOP);
    check("arst_seq", seq_PC_o, 16'h0000);
    check("arst_addr", imem_addr_o, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check("rel_req", imem_req_o, 1'b1);
    check("rel_addr", imem_addr_o, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0, 100);

    // Random stalls, redirects and memory latency.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
            {7'b0, 8'($urandom), 1'b0}, 60);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
